// File: rtl/burst_xfer_engine_if.sv
// Read-master and write-master bus bundle for burst_xfer_engine.
// A beat moves on any cycle where the strobe is high and waitrequest is low; readdatavalid has no backpressure.
interface burst_xfer_engine_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int BURST_W = 13
) ();
  logic               avm_rx_waitrequest;
  logic [BURST_W-1:0] avm_rx_burstcount;
  logic [ADDR_W-1:0]  avm_rx_address;
  logic               avm_rx_read;
  logic [DATA_W-1:0]  avm_rx_readdata;
  logic               avm_rx_readdatavalid;
  logic               avm_tx_waitrequest;
  logic [BURST_W-1:0] avm_tx_burstcount;
  logic [ADDR_W-1:0]  avm_tx_address;
  logic               avm_tx_write;
  logic [DATA_W-1:0]  avm_tx_writedata;

  modport master (
    input  avm_rx_waitrequest, avm_rx_readdata, avm_rx_readdatavalid, avm_tx_waitrequest,
    output avm_rx_burstcount, avm_rx_address, avm_rx_read,
    output avm_tx_burstcount, avm_tx_address, avm_tx_write, avm_tx_writedata
  );

  modport slave (
    output avm_rx_waitrequest, avm_rx_readdata, avm_rx_readdatavalid, avm_tx_waitrequest,
    input  avm_rx_burstcount, avm_rx_address, avm_rx_read,
    input  avm_tx_burstcount, avm_tx_address, avm_tx_write, avm_tx_writedata
  );
endinterface

// File: rtl/burst_xfer_engine.sv
// Burst transfer engine: reads a burst into a local buffer, writes it back out (optionally byte-filtered),
// or does both as a copy. Errors are sticky until clr_err.
module burst_xfer_engine #(
  parameter int         DATA_W     = 32,
  parameter int         ADDR_W     = 32,
  parameter int         DEPTH_LOG2 = 12,
  parameter logic [7:0] FILL_BYTE  = 8'h20,
  localparam int        BURST_W    = DEPTH_LOG2 + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               clr_err,
  input  logic [1:0]         cfg_mode,
  input  logic [BURST_W-1:0] cfg_length,
  input  logic [ADDR_W-1:0]  cfg_rd_addr,
  input  logic [ADDR_W-1:0]  cfg_wr_addr,
  input  logic               cfg_filter_en,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [1:0]         err_code,
  output logic [2:0]         dbg_state,
  burst_xfer_engine_if.master avm
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, RD_REQ = 3'd1, RD_DATA = 3'd2, WR = 3'd3, DONE = 3'd4
  } state_t;

  localparam logic [BURST_W-1:0] MAX_LEN = BURST_W'(1) << DEPTH_LOG2;

  state_t             state_q, state_nx;
  logic [BURST_W-1:0] idx_q;
  logic [1:0]         mode_q;
  logic [BURST_W-1:0] len_q;
  logic [ADDR_W-1:0]  rd_addr_q, wr_addr_q;
  logic               filter_q;
  logic               error_q;
  logic [1:0]         err_code_q;
  logic [DATA_W-1:0]  buf_mem [2**DEPTH_LOG2];
  logic [DATA_W-1:0]  rd_word;

  logic len_ok, mode_ok, start_ok, in_rd, idx_last, beat, last_beat, wr_accept;

  assign len_ok    = (cfg_length != '0) && (cfg_length <= MAX_LEN);
  assign mode_ok   = (cfg_mode != 2'd3);
  assign start_ok  = (state_q == IDLE) && start && !clr_err && !error_q && len_ok && mode_ok;
  assign in_rd     = (state_q == RD_REQ) || (state_q == RD_DATA);
  assign idx_last  = (idx_q == (len_q - BURST_W'(1)));
  assign beat      = in_rd && avm.avm_rx_readdatavalid;
  assign last_beat = beat && idx_last;
  assign wr_accept = (state_q == WR) && !avm.avm_tx_waitrequest;
  assign rd_word   = buf_mem[idx_q[DEPTH_LOG2-1:0]];

  function automatic logic [DATA_W-1:0] filter_word(input logic [DATA_W-1:0] w);
    logic [7:0] b;
    filter_word = '0;
    for (int i = 0; i < DATA_W / 8; i++) begin
      b = w[i*8 +: 8];
      case (b)
        8'h0a, 8'h27, 8'h28, 8'h29, 8'h2c, 8'h2f,
        8'h3c, 8'h5c, 8'h5f, 8'h60, 8'h7c: filter_word[i*8 +: 8] = b;
        default:                            filter_word[i*8 +: 8] = FILL_BYTE;
      endcase
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nx;
  end

  // A final beat that lands while the request is still stalled still ends the read phase.
  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_nx = (cfg_mode == 2'd1) ? WR : RD_REQ;
      RD_REQ:  if (last_beat) state_nx = (mode_q == 2'd2) ? WR : DONE;
               else if (!avm.avm_rx_waitrequest) state_nx = RD_DATA;
      RD_DATA: if (last_beat) state_nx = (mode_q == 2'd2) ? WR : DONE;
      WR:      if (wr_accept && idx_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy                 = 1'b0;
    done                 = 1'b0;
    avm.avm_rx_read      = 1'b0;
    avm.avm_rx_address   = '0;
    avm.avm_tx_write     = 1'b0;
    avm.avm_tx_address   = '0;
    avm.avm_tx_writedata = '0;
    unique case (state_q)
      RD_REQ: begin
        busy               = 1'b1;
        avm.avm_rx_read    = 1'b1;
        avm.avm_rx_address = rd_addr_q;
      end
      RD_DATA: busy = 1'b1;
      WR: begin
        busy                 = 1'b1;
        avm.avm_tx_write     = 1'b1;
        avm.avm_tx_address   = wr_addr_q;
        avm.avm_tx_writedata = filter_q ? filter_word(rd_word) : rd_word;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // clr_err wins over start; a start seen with error set is dropped entirely.
  always_ff @(posedge clk) begin
    if (rst) begin
      error_q    <= 1'b0;
      err_code_q <= 2'd0;
      mode_q     <= 2'd0;
      len_q      <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      filter_q   <= 1'b0;
      idx_q      <= '0;
    end else begin
      if (clr_err) begin
        error_q    <= 1'b0;
        err_code_q <= 2'd0;
      end else if (start && !error_q) begin
        if (busy) begin
          error_q    <= 1'b1;
          err_code_q <= 2'd1;
        end else if (state_q == IDLE) begin
          if (!len_ok) begin
            error_q    <= 1'b1;
            err_code_q <= 2'd2;
          end else if (!mode_ok) begin
            error_q    <= 1'b1;
            err_code_q <= 2'd3;
          end else begin
            mode_q    <= cfg_mode;
            len_q     <= cfg_length;
            rd_addr_q <= cfg_rd_addr;
            wr_addr_q <= cfg_wr_addr;
            filter_q  <= cfg_filter_en;
          end
        end
      end
      if (beat || wr_accept) idx_q <= idx_last ? '0 : idx_q + BURST_W'(1);
    end
  end

  // Buffer has no reset so write-only transfers can replay earlier contents.
  always_ff @(posedge clk) begin
    if (!rst && beat) buf_mem[idx_q[DEPTH_LOG2-1:0]] <= avm.avm_rx_readdata;
  end

  assign avm.avm_rx_burstcount = len_q;
  assign avm.avm_tx_burstcount = len_q;
  assign error                 = error_q;
  assign err_code              = err_code_q;
  assign dbg_state             = state_q;
endmodule

// File: tb/tb_burst_xfer_engine.sv
// Self-checking bench for burst_xfer_engine: randomized bus responders plus a buffer-level reference model.
module tb_burst_xfer_engine;
  localparam int DATA_W = 32, ADDR_W = 32, DEPTH_LOG2 = 4;
  localparam int BURST_W = DEPTH_LOG2 + 1, DEPTH = 1 << DEPTH_LOG2;
  localparam logic [7:0] FILL = 8'h20;

  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, clr_err = 1'b0, cfg_filter_en = 1'b0;
  logic [1:0] cfg_mode = 2'd0;
  logic [BURST_W-1:0] cfg_length = '0;
  logic [ADDR_W-1:0] cfg_rd_addr = '0, cfg_wr_addr = '0;
  logic busy, done, error;
  logic [1:0] err_code;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  burst_xfer_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) avm ();

  burst_xfer_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2), .FILL_BYTE(FILL)) dut (
    .clk(clk), .rst(rst), .start(start), .clr_err(clr_err), .cfg_mode(cfg_mode),
    .cfg_length(cfg_length), .cfg_rd_addr(cfg_rd_addr), .cfg_wr_addr(cfg_wr_addr),
    .cfg_filter_en(cfg_filter_en), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .dbg_state(dbg_state), .avm(avm)
  );

  int checks = 0, errors = 0, cyc = 0, done_at = 0;
  logic [63:0] exp_q[$];
  logic [63:0] wr_obs_q[$];
  logic [DATA_W-1:0] rx_sent_q[$];
  logic [DATA_W-1:0] model_buf [DEPTH];
  logic [7:0] ok_bytes [11] = '{8'h0a, 8'h27, 8'h28, 8'h29, 8'h2c, 8'h2f, 8'h3c, 8'h5c, 8'h5f, 8'h60, 8'h7c};

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- read slave ----------------
  bit rx_rand = 0, rx_fixed_en = 0;
  logic [31:0] rx_fixed = '0;
  int rx_wait_budget = 0, rx_wait_used = 0, rx_pending = 0, rd_hi_cyc = 0;

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++)
      w[8*i +: 8] = ($urandom_range(0, 1) == 1) ? ok_bytes[$urandom_range(0, 10)] : 8'($urandom);
    return w;
  endfunction

  initial begin
    logic [31:0] d;
    avm.avm_rx_waitrequest = 1'b0;
    avm.avm_rx_readdatavalid = 1'b0;
    avm.avm_rx_readdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rx_pending = 0;
        avm.avm_rx_readdatavalid = 1'b0;
        avm.avm_rx_waitrequest = 1'b0;
      end else begin
        if (rx_pending > 0 && (!rx_rand || $urandom_range(0, 3) != 0)) begin
          d = rx_fixed_en ? rx_fixed : rand_word();
          avm.avm_rx_readdatavalid = 1'b1;
          avm.avm_rx_readdata = d;
          rx_sent_q.push_back(d);
          rx_pending--;
        end else begin
          avm.avm_rx_readdatavalid = 1'b0;
          avm.avm_rx_readdata = '0;
        end
        if (avm.avm_rx_read) begin
          rd_hi_cyc++;
          if (rx_wait_used < rx_wait_budget) begin
            avm.avm_rx_waitrequest = 1'b1;
            rx_wait_used++;
          end else begin
            avm.avm_rx_waitrequest = rx_rand ? 1'($urandom_range(0, 1)) : 1'b0;
          end
          if (!avm.avm_rx_waitrequest) rx_pending += int'(avm.avm_rx_burstcount);
        end else begin
          avm.avm_rx_waitrequest = 1'b0;
        end
      end
    end
  end

  // ---------------- write slave ----------------
  bit tx_rand = 0, tx_toggle = 0;
  int wr_cyc = 0, last_wr_cyc = 0;

  initial begin
    avm.avm_tx_waitrequest = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_toggle)    avm.avm_tx_waitrequest = ~avm.avm_tx_waitrequest;
      else if (tx_rand) avm.avm_tx_waitrequest = 1'($urandom_range(0, 1));
      else              avm.avm_tx_waitrequest = 1'b0;
      if (avm.avm_tx_write) begin
        wr_cyc++;
        if (!avm.avm_tx_waitrequest && !rst) begin
          wr_obs_q.push_back({avm.avm_tx_address, avm.avm_tx_writedata});
          last_wr_cyc = cyc;
        end
      end
    end
  end

  // ---------------- passive monitor ----------------
  int viol = 0, busy_cyc = 0;
  always @(negedge clk) begin
    if (!avm.avm_rx_read && avm.avm_rx_address != '0) viol++;
    if (!avm.avm_tx_write && (avm.avm_tx_address != '0 || avm.avm_tx_writedata != '0)) viol++;
    if (busy) busy_cyc++;
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_filter(input logic [31:0] w, input bit en);
    logic [7:0] b;
    ref_filter = w;
    if (en)
      for (int i = 0; i < 4; i++) begin
        b = w[8*i +: 8];
        if (!(b inside {8'h0a, 8'h27, 8'h28, 8'h29, 8'h2c, 8'h2f, 8'h3c, 8'h5c, 8'h5f, 8'h60, 8'h7c}))
          ref_filter[8*i +: 8] = FILL;
      end
  endfunction

  // Reads land in the buffer in arrival order; writes replay buffer[0..len-1] to the write address.
  function automatic void model_apply(input logic [1:0] m, input int len, input logic [31:0] wa, input bit f);
    exp_q.delete();
    if (m != 2'd1)
      for (int i = 0; i < len; i++)
        if (rx_sent_q.size() > 0) model_buf[i] = rx_sent_q.pop_front();
    if (m != 2'd0)
      for (int i = 0; i < len; i++) exp_q.push_back({wa, ref_filter(model_buf[i], f)});
  endfunction

  // ---------------- drivers ----------------
  task automatic pulse_start(input logic [1:0] m, input int len, input logic [31:0] ra,
                             input logic [31:0] wa, input bit f);
    logic [31:0] l;
    l = len;
    @(negedge clk);
    cfg_mode = m; cfg_length = l[BURST_W-1:0]; cfg_rd_addr = ra; cfg_wr_addr = wa; cfg_filter_en = f;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        ok = 1;
        done_at = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, error} !== 3'b000) begin errors++; $display("FAIL reset_status got %b exp 000", {busy, done, error}); end
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code got %0d exp 0", err_code); end
    checks++; if ({avm.avm_rx_read, avm.avm_tx_write} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b exp 00", {avm.avm_rx_read, avm.avm_tx_write}); end
    checks++; if ({avm.avm_rx_burstcount, avm.avm_tx_burstcount} !== '0) begin errors++; $display("FAIL reset_burstcount got %h exp 0", {avm.avm_rx_burstcount, avm.avm_tx_burstcount}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_copy_filter();
    bit ok;
    rx_fixed_en = 1; rx_fixed = 32'h41270A5C; rx_rand = 0; tx_rand = 0;
    wr_obs_q.delete();
    pulse_start(2'd2, 4, 32'h1000, 32'h2000, 1'b1);
    checks++; if ({avm.avm_rx_read, avm.avm_rx_address} !== {1'b1, 32'h1000}) begin errors++; $display("FAIL copy_rd_req got %b/%h exp 1/00001000", avm.avm_rx_read, avm.avm_rx_address); end
    checks++; if (avm.avm_rx_burstcount !== 5'd4) begin errors++; $display("FAIL copy_burstcount got %0d exp 4", avm.avm_rx_burstcount); end
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL copy_timeout got no done exp done"); end
    checks++; if (done_at - last_wr_cyc != 1) begin errors++; $display("FAIL copy_done_latency got %0d exp 1", done_at - last_wr_cyc); end
    model_apply(2'd2, 4, 32'h2000, 1'b1);
    checks++; if (wr_obs_q.size() != 4) begin errors++; $display("FAIL copy_wr_count got %0d exp 4", wr_obs_q.size()); end
    for (int i = 0; i < wr_obs_q.size(); i++) begin
      checks++; if (wr_obs_q[i] !== 64'h00002000_20270A5C) begin errors++; $display("FAIL copy_wr[%0d] got %h exp 0000200020270a5c", i, wr_obs_q[i]); end
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL copy_done_pulse got %b exp 0", done); end
    rx_fixed_en = 0;
  endtask

  task automatic test_read_wait();
    bit ok;
    int rd0, wr0;
    logic [31:0] wa;
    rd0 = rd_hi_cyc; wr0 = wr_cyc;
    rx_wait_budget = rx_wait_used + 5;
    pulse_start(2'd0, 3, 32'h0000_4000, 32'h0000_5000, 1'b0);
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rdwait_timeout got no done exp done"); end
    checks++; if (rd_hi_cyc - rd0 != 6) begin errors++; $display("FAIL rdwait_read_cycles got %0d exp 6", rd_hi_cyc - rd0); end
    checks++; if (rx_sent_q.size() != 3) begin errors++; $display("FAIL rdwait_beats got %0d exp 3", rx_sent_q.size()); end
    checks++; if (wr_cyc != wr0) begin errors++; $display("FAIL rdwait_tx_write got %0d cycles exp 0", wr_cyc - wr0); end
    model_apply(2'd0, 3, 32'h0, 1'b0);
    // Write-only replay shows exactly the three stored beats.
    wa = $urandom & 32'hFFFF_FFFC;
    wr_obs_q.delete();
    pulse_start(2'd1, 3, 32'h0, wa, 1'b0);
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL replay_timeout got no done exp done"); end
    model_apply(2'd1, 3, wa, 1'b0);
    checks++; if (wr_obs_q.size() != exp_q.size()) begin errors++; $display("FAIL replay_count got %0d exp %0d", wr_obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_obs_q.size(); i++) begin
      checks++; if (wr_obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL replay_wr[%0d] got %h exp %h", i, wr_obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_start_busy();
    bit ok, f;
    logic [31:0] ra, wa;
    rx_rand = 1; tx_rand = 1;
    ra = $urandom & 32'hFFFF_FFFC; wa = $urandom & 32'hFFFF_FFFC; f = 1'($urandom_range(0, 1));
    wr_obs_q.delete();
    pulse_start(2'd2, 8, ra, wa, f);
    repeat (2) @(negedge clk);
    pulse_start(2'd0, 1, 32'h0, 32'h0, 1'b0);
    checks++; if ({error, err_code, busy} !== {1'b1, 2'd1, 1'b1}) begin errors++; $display("FAIL busy_start got err=%b code=%0d busy=%b exp 1/1/1", error, err_code, busy); end
    wait_done(600, ok);
    checks++; if (!ok) begin errors++; $display("FAIL busy_timeout got no done exp done"); end
    model_apply(2'd2, 8, wa, f);
    checks++; if (wr_obs_q.size() != exp_q.size()) begin errors++; $display("FAIL busy_wr_count got %0d exp %0d", wr_obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_obs_q.size(); i++) begin
      checks++; if (wr_obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL busy_wr[%0d] got %h exp %h", i, wr_obs_q[i], exp_q[i]); end
    end
    // A legal start while the error is latched must not launch anything.
    pulse_start(2'd0, 2, 32'h100, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if ({busy, error, err_code} !== {1'b0, 1'b1, 2'd1}) begin errors++; $display("FAIL err_ignore got busy=%b err=%b code=%0d exp 0/1/1", busy, error, err_code); end
    cfg_mode = 2'd0; cfg_length = 5'd2;
    clr_err = 1'b1; start = 1'b1;
    @(negedge clk);
    clr_err = 1'b0; start = 1'b0;
    checks++; if ({error, err_code, busy} !== {1'b0, 2'd0, 1'b0}) begin errors++; $display("FAIL clr_priority got err=%b code=%0d busy=%b exp 0/0/0", error, err_code, busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_start_dropped got busy=%b exp 0", busy); end
  endtask

  task automatic test_bad_cfg();
    int b0;
    int lens [4] = '{0, DEPTH + 1, 4, 0};
    logic [1:0] modes [4] = '{2'd0, 2'd2, 2'd3, 2'd3};
    logic [1:0] codes [4] = '{2'd2, 2'd2, 2'd3, 2'd2};
    b0 = busy_cyc;
    for (int k = 0; k < 4; k++) begin
      pulse_start(modes[k], lens[k], 32'h40, 32'h80, 1'b0);
      checks++; if ({error, err_code} !== {1'b1, codes[k]}) begin errors++; $display("FAIL badcfg[%0d] got err=%b code=%0d exp 1/%0d", k, error, err_code, codes[k]); end
      @(negedge clk); clr_err = 1'b1;
      @(negedge clk); clr_err = 1'b0;
      checks++; if ({error, err_code} !== 3'b000) begin errors++; $display("FAIL badcfg_clr[%0d] got err=%b code=%0d exp 0/0", k, error, err_code); end
    end
    checks++; if (busy_cyc != b0) begin errors++; $display("FAIL badcfg_busy got %0d busy cycles exp 0", busy_cyc - b0); end
  endtask

  task automatic test_random();
    bit ok, f;
    int len, v0;
    logic [1:0] m;
    logic [31:0] ra, wa;
    rx_rand = 1; tx_rand = 1; v0 = viol;
    for (int t = 0; t < 10; t++) begin
      m = (t == 0) ? 2'd0 : 2'($urandom_range(0, 2));
      len = (t == 0) ? DEPTH : $urandom_range(1, DEPTH);
      ra = $urandom & 32'hFFFF_FFFC; wa = $urandom & 32'hFFFF_FFFC; f = 1'($urandom_range(0, 1));
      wr_obs_q.delete();
      pulse_start(m, len, ra, wa, f);
      wait_done(1000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand[%0d]_timeout got no done exp done", t); end
      model_apply(m, len, wa, f);
      checks++; if (wr_obs_q.size() != exp_q.size() || rx_sent_q.size() != 0) begin errors++; $display("FAIL rand[%0d]_count got wr=%0d extra_rd=%0d exp wr=%0d extra_rd=0", t, wr_obs_q.size(), rx_sent_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < wr_obs_q.size(); i++) begin
        checks++; if (wr_obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand[%0d]_wr[%0d] got %h exp %h", t, i, wr_obs_q[i], exp_q[i]); end
      end
      rx_sent_q.delete();
      @(negedge clk);
    end
    checks++; if (viol != v0) begin errors++; $display("FAIL idle_bus_zero got %0d violations exp 0", viol - v0); end
  endtask

  task automatic test_reset_mid_wr();
    bit ok;
    logic [31:0] wa;
    tx_rand = 0; tx_toggle = 1;
    pulse_start(2'd1, 6, 32'h0, 32'h0000_7000, 1'b1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({busy, done, error, err_code, avm.avm_rx_read, avm.avm_tx_write} !== 7'b0) begin errors++; $display("FAIL rstwr_status got %b exp 0000000", {busy, done, error, err_code, avm.avm_rx_read, avm.avm_tx_write}); end
    checks++; if ({avm.avm_tx_burstcount, avm.avm_tx_address, avm.avm_tx_writedata} !== '0) begin errors++; $display("FAIL rstwr_bus got %h exp 0", {avm.avm_tx_burstcount, avm.avm_tx_address, avm.avm_tx_writedata}); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL rstwr_state got %0d exp 0", dbg_state); end
    rst = 1'b0; tx_toggle = 0; tx_rand = 1;
    @(negedge clk);
    wr_obs_q.delete();
    wa = $urandom & 32'hFFFF_FFFC;
    pulse_start(2'd1, 6, 32'h0, wa, 1'b0);
    wait_done(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstwr_timeout got no done exp done"); end
    model_apply(2'd1, 6, wa, 1'b0);
    checks++; if (wr_obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rstwr_count got %0d exp %0d", wr_obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_obs_q.size(); i++) begin
      checks++; if (wr_obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstwr_wr[%0d] got %h exp %h", i, wr_obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_copy_filter();
    test_read_wait();
    test_start_busy();
    test_bad_cfg();
    test_random();
    test_reset_mid_wr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/burst_xfer_engine.md
BURST_XFER_ENGINE -- requirements
Module: burst_xfer_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data bus width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte address width.
REQ-003 SHALL have parameter DEPTH_LOG2, default 12, meaning buffer depth 2**DEPTH_LOG2 words; BURST_W = DEPTH_LOG2+1.
REQ-004 SHALL have parameter FILL_BYTE, default 8'h20, meaning replacement byte for filtered data.
REQ-005 Ports SHALL be:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle transfer request
clr_err  in  1  clears error state
cfg_mode  in  2  0 read-only, 1 write-only, 2 copy (read then write), 3 illegal
cfg_length  in  BURST_W  burst length in words
cfg_rd_addr  in  ADDR_W  read base address
cfg_wr_addr  in  ADDR_W  write base address
cfg_filter_en  in  1  enables byte filter on write data
busy  out  1  transfer in progress
done  out  1  one-cycle completion pulse
error  out  1  sticky error
err_code  out  2  0 none, 1 start-while-busy, 2 bad length, 3 bad mode
avm_rx_waitrequest  in  1  read-master stall
avm_rx_burstcount  out  BURST_W  latched length
avm_rx_address  out  ADDR_W  read address
avm_rx_read  out  1  read request
avm_rx_readdata  in  DATA_W  read data
avm_rx_readdatavalid  in  1  read data valid
avm_tx_waitrequest  in  1  write-master stall
avm_tx_burstcount  out  BURST_W  latched length
avm_tx_address  out  ADDR_W  write address
avm_tx_write  out  1  write request
avm_tx_writedata  out  DATA_W  write data
REQ-006 Clock SHALL be clk; reset SHALL be rst, synchronous and active-high.

Function
REQ-007 States SHALL be IDLE, RD_REQ, RD_DATA, WR, DONE.
REQ-008 In IDLE with start=1, error=0, clr_err=0, legal mode and 1<=cfg_length<=2**DEPTH_LOG2, config SHALL be latched and next state SHALL be RD_REQ (modes 0,2) or WR (mode 1).
REQ-009 Illegal length or mode at start in IDLE SHALL set error with err_code 2 (length checked first) or 3, and SHALL stay IDLE.
REQ-010 start while busy SHALL set error, err_code=1; the running transfer SHALL continue unaffected.
REQ-011 start while error=1 SHALL be ignored; clr_err SHALL clear error and err_code next cycle and SHALL take priority over a coincident start, which is dropped.
REQ-012 RD_REQ: avm_rx_read=1, address=latched rd addr; on cycle with waitrequest=0 read SHALL drop next cycle, state -> RD_DATA.
REQ-013 Every readdatavalid beat in RD_REQ or RD_DATA SHALL write buffer[idx], idx starting 0, incrementing per beat; beats in other states SHALL be ignored.
REQ-014 After beat idx=length-1: mode 0 -> DONE, mode 2 -> WR with idx reset to 0.
REQ-015 WR: avm_tx_write=1, address=latched wr addr, writedata=buffer[idx] (filtered if enabled), idx advancing on each cycle waitrequest=0; after last accepted beat write SHALL drop next cycle, state -> DONE.
REQ-016 Filter: each byte lane SHALL pass if in {0a,27,28,29,2c,2f,3c,5c,5f,60,7c} hex, else SHALL become FILL_BYTE.
REQ-017 Write-only mode SHALL send existing buffer contents; buffer SHALL not be reset.
REQ-018 busy SHALL be 1 in RD_REQ, RD_DATA, WR, 0 in IDLE and DONE; done SHALL be 1 only in DONE; DONE -> IDLE unconditionally.
REQ-019 Addresses and writedata SHALL be 0 when their strobe is 0; burstcounts SHALL always show latched length.

Reset
REQ-020 rst=1 at any clock edge, including mid-transfer, SHALL force IDLE, busy=0, done=0, error=0, err_code=0, avm_rx_read=0, avm_tx_write=0, idx=0, latched config=0; buffer contents SHALL be retained.

Verification
REQ-021 Mode 2, length 4, rd 0x1000, wr 0x2000, filter on, readdata 0x41270A5C, no waits -> writes 0x20270A5C x4 at 0x2000, done one cycle after last write.
REQ-022 Mode 0, length 3, rx_waitrequest high 5 cycles -> read held 6 cycles, 3 beats stored, done, tx_write never asserted.
REQ-023 start during copy transfer -> error=1, err_code=1, transfer completes; start ignored; clr_err -> error=0.
REQ-024 start with length 0, then 2**DEPTH_LOG2+1, then mode 3 -> err_code 2, 2 (after clr_err), 3; busy never asserted.
REQ-025 rst=1 mid-WR with tx_waitrequest toggling -> next cycle all outputs at reset values; subsequent mode 1 replays buffer unchanged.
